// File: rtl/mem_responder.sv
// mem_responder: byte-wide memory-side responder with internal RAM, a TX FIFO
// drained by an external sink, an optional RX FIFO filled by an external
// source, and a sticky halt flag, all reached through a small IO page.
//
// Build option: define MEM_RESPONDER_RX_FIFO_EN to include the RX FIFO and
// its IO offsets (0x0 read = RX head, 0x1 write = pop). Without it no RX
// storage exists, rx_ready_o is tied low and status rx_empty reads 1.
//
// Address map:
//   addr[17:16] == 2'b11          -> IO page, offset addr[3:0]
//   else addr < 2**RAM_ADDR_W     -> RAM
//   else                          -> unmapped (reads 0x00, writes dropped)
// IO page decode wins over RAM so the page is reachable for any RAM size.

module mem_responder #(
  parameter int RAM_ADDR_W    = 17,
  parameter int TX_DEPTH_LOG2 = 3,
  parameter int RX_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_i,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  mem_din_i,
  output logic [7:0]  mem_dout_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        halt_o
);

  localparam int          TX_DEPTH  = 1 << TX_DEPTH_LOG2;
  localparam logic [32:0] RAM_BYTES = 33'(1) << RAM_ADDR_W;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_POP    = 4'h1;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_HALT   = 4'h8;

  // ---------------------------------------------------------------------------
  // Address decode and cycle qualification
  // ---------------------------------------------------------------------------
  logic       io_sel;
  logic       ram_sel;
  logic [3:0] io_off;
  logic       wr_cyc;
  logic       rd_cyc;
  logic       io_wr;

  assign io_sel  = (mem_addr_i[17:16] == 2'b11);
  assign ram_sel = !io_sel && ({1'b0, mem_addr_i} < RAM_BYTES);
  assign io_off  = mem_addr_i[3:0];
  // rdy_i low freezes every memory-side effect; FIFO handshakes keep running.
  assign wr_cyc  = rdy_i && mem_wr_i;
  assign rd_cyc  = rdy_i && !mem_wr_i;
  assign io_wr   = wr_cyc && io_sel;

  // ---------------------------------------------------------------------------
  // RAM (contents are intentionally not reset)
  // ---------------------------------------------------------------------------
  logic [7:0] ram [2**RAM_ADDR_W];
  logic [7:0] ram_rd;

  assign ram_rd = ram[mem_addr_i[RAM_ADDR_W-1:0]];

  // Byte write into RAM on a qualified write cycle to a RAM address.
  always_ff @(posedge clk) begin
    if (wr_cyc && ram_sel) begin
      ram[mem_addr_i[RAM_ADDR_W-1:0]] <= mem_din_i;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO: pushed from IO offset 0x0, drained by the sink handshake.
  // Fullness is judged on the registered count, so a push arriving while full
  // is dropped even if the sink frees a slot on the same edge.
  // ---------------------------------------------------------------------------
  logic [7:0]               tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr;
  logic [TX_DEPTH_LOG2-1:0] tx_rd_ptr;
  logic [TX_DEPTH_LOG2:0]   tx_count;
  logic                     tx_full;
  logic                     tx_push_req;
  logic                     tx_push;
  logic                     tx_drop;
  logic                     tx_pop;

  assign tx_full     = (tx_count == (TX_DEPTH_LOG2+1)'(TX_DEPTH));
  assign tx_valid_o  = (tx_count != '0);
  assign tx_data_o   = tx_mem[tx_rd_ptr];
  assign tx_push_req = io_wr && (io_off == OFF_DATA);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_drop     = tx_push_req && tx_full;
  assign tx_pop      = tx_valid_o && tx_ready_i;

  // TX storage write; contents need no reset because the count gates validity.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= mem_din_i;
    end
  end

  // TX pointers and occupancy; reset discards any queued bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + TX_DEPTH_LOG2'(1);
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + TX_DEPTH_LOG2'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_DEPTH_LOG2+1)'(1);
        2'b01:   tx_count <= tx_count - (TX_DEPTH_LOG2+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO: filled by the source handshake, popped from IO offset 0x1.
  // ---------------------------------------------------------------------------
  logic [RX_DEPTH_LOG2:0] rx_count;
  logic [7:0]             rx_head;
  logic                   rx_empty;

  assign rx_empty = (rx_count == '0);

`ifdef MEM_RESPONDER_RX_FIFO_EN
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;

  logic [7:0]               rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr;
  logic [RX_DEPTH_LOG2-1:0] rx_rd_ptr;
  logic                     rx_full;
  logic                     rx_fill;
  logic                     rx_pop;

  assign rx_full    = (rx_count == (RX_DEPTH_LOG2+1)'(RX_DEPTH));
  assign rx_ready_o = !rx_full;
  assign rx_fill    = rx_valid_i && rx_ready_o;
  assign rx_pop     = io_wr && (io_off == OFF_POP) && !rx_empty;
  assign rx_head    = rx_mem[rx_rd_ptr];

  // RX storage write from the source handshake.
  always_ff @(posedge clk) begin
    if (rx_fill) begin
      rx_mem[rx_wr_ptr] <= rx_data_i;
    end
  end

  // RX pointers and occupancy; reset discards any buffered bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_fill) begin
        rx_wr_ptr <= rx_wr_ptr + RX_DEPTH_LOG2'(1);
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + RX_DEPTH_LOG2'(1);
      end
      case ({rx_fill, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_DEPTH_LOG2+1)'(1);
        2'b01:   rx_count <= rx_count - (RX_DEPTH_LOG2+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end
`else
  // No RX path: the FIFO looks permanently empty and never accepts data.
  logic unused_rx;

  assign rx_count   = '0;
  assign rx_head    = 8'h00;
  assign rx_ready_o = 1'b0;
  assign unused_rx  = ^{rx_data_i, rx_valid_i};
`endif

  // ---------------------------------------------------------------------------
  // Overflow and halt flags
  // ---------------------------------------------------------------------------
  logic ovf;

  // ovf latches a dropped TX push and is cleared by a write to the status offset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (tx_drop) begin
      ovf <= 1'b1;
    end else if (io_wr && (io_off == OFF_STATUS)) begin
      ovf <= 1'b0;
    end
  end

  // halt_o is set by any write to the halt offset and only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_o <= 1'b0;
    end else if (io_wr && (io_off == OFF_HALT)) begin
      halt_o <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [7:0] rd_data;

  // Select the read byte; IO reads are side-effect free, unmapped reads are 0.
  always_comb begin
    rd_data = 8'h00;
    if (io_sel) begin
      case (io_off)
        OFF_DATA:   rd_data = rx_empty ? 8'h00 : rx_head;
        OFF_STATUS: rd_data = {5'b0, ovf, rx_empty, tx_full};
        default:    rd_data = 8'h00;
      endcase
    end else if (ram_sel) begin
      rd_data = ram_rd;
    end
  end

  // Register the read byte on read cycles; hold it on writes and while frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_dout_o <= 8'h00;
    end else if (rd_cyc) begin
      mem_dout_o <= rd_data;
    end
  end

endmodule
